// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: datapath widths, requester count and the broadcast record.
// Latency: none (types and constants only).
// Backpressure: not applicable.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package cdb_arbiter_pkg;

  // Number of functional units sharing the common data bus.
  localparam int CDB_NUM_REQ = 4;

  // One broadcast on the CDB: completion of the ROB entry named by rob_tag.
  typedef struct packed {
    logic                    valid;
    logic [`ROB_TAG_LEN-1:0] rob_tag;
    logic [`XLEN-1:0]        value;
  } CDB_DATA;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB bundle: per-FU result offers, per-FU accepts and the broadcast record.
// Latency: none (wiring only).
// Backpressure: fu_ready low means the FU must hold its offered result.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ
);

  logic [NUM_REQ-1:0]                   fu_valid;
  logic [NUM_REQ-1:0][`ROB_TAG_LEN-1:0] fu_rob_tag;
  logic [NUM_REQ-1:0][`XLEN-1:0]        fu_value;
  logic [NUM_REQ-1:0]                   fu_ready;
  CDB_DATA                              cdb_data;

  // Functional-unit side: offers results, watches accepts and the bus.
  modport master (
    output fu_valid, fu_rob_tag, fu_value,
    input  fu_ready, cdb_data
  );

  // Arbiter side.
  modport slave (
    input  fu_valid, fu_rob_tag, fu_value,
    output fu_ready, cdb_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit searching upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is one-hot or all-zero when req is empty.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at ptr and keep the first one asking.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one skid entry per FU, round-robin grant, registered broadcast; CDB_ARB_STATS_EN adds stall counters.
// Latency: 1 cycle from an unbuffered accepted fu_valid to cdb_data.valid.
// Backpressure: fu_ready[i] = !buf_valid[i]; a losing FU is captured, then held off until drained.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stall_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                   buf_valid;
  logic [NUM_REQ-1:0][`ROB_TAG_LEN-1:0] buf_tag;
  logic [NUM_REQ-1:0][`XLEN-1:0]        buf_value;
  logic [PTR_W-1:0]                     rr_ptr;

  logic [NUM_REQ-1:0] candidate;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               any_grant;
  CDB_DATA            cdb_q;

  // Ready depends only on buffer occupancy, so there is no path from fu_valid.
  assign bus.fu_ready = ~buf_valid;
  assign bus.cdb_data = cdb_q;

  // A buffered entry stands in for its FU; otherwise a live offer competes.
  assign candidate = buf_valid | bus.fu_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (candidate),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Encode the one-hot grant into an index for muxing and pointer advance.
  always_comb begin
    grant_idx = '0;
    any_grant = |grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Round-robin pointer moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= next_ptr;
    end
  end

  // Register the winner onto the CDB, preferring the buffered copy of that FU.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_q <= '0;
    end else if (any_grant) begin
      cdb_q.valid   <= 1'b1;
      cdb_q.rob_tag <= buf_valid[grant_idx] ? buf_tag[grant_idx]   : bus.fu_rob_tag[grant_idx];
      cdb_q.value   <= buf_valid[grant_idx] ? buf_value[grant_idx] : bus.fu_value[grant_idx];
    end else begin
      cdb_q <= '0;
    end
  end

  // Per-FU skid entry: bypass on win, capture on loss, drain on win, else hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (buf_valid[i]) begin
          if (grant[i]) begin
            buf_valid[i] <= 1'b0;
          end
        end else if (bus.fu_valid[i] && !grant[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= bus.fu_rob_tag[i];
          buf_value[i] <= bus.fu_value[i];
        end
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  // Count cycles a buffered result waits without a grant, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (buf_valid[i] && !grant[i] && (stall_count[i] != '1)) begin
          stall_count[i] <= stall_count[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of functional-unit (FU) requesters sharing the CDB.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 SHALL have port fu_valid  input  NUM_REQ  per-FU result valid.
REQ-005 SHALL have port fu_rob_tag  input  NUM_REQ x `ROB_TAG_LEN  per-FU destination ROB tag.
REQ-006 SHALL have port fu_value  input  NUM_REQ x `XLEN  per-FU result value (a store address for address-calc FUs).
REQ-007 SHALL have port fu_ready  output  NUM_REQ  per-FU accept indication.
REQ-008 SHALL have port cdb_data  output  CDB_DATA  registered broadcast to the ROB and reservation stations.

Function
REQ-009 SHALL hold one entry per requester (buf_valid, tag, value).
REQ-010 SHALL drive fu_ready[i] = !buf_valid[i], a pure function of registered state with no combinational path from fu_valid.
REQ-011 SHALL treat result i as accepted in a cycle where fu_valid[i] && fu_ready[i]; fu_valid[i] while !fu_ready[i] SHALL be ignored, and the FU holds its result.
REQ-012 SHALL, per cycle, form candidate[i] = buf_valid[i] || (fu_valid[i] && !buf_valid[i]); a buffered entry takes precedence over new input for requester i.
REQ-013 SHALL grant at most one candidate per cycle, round-robin: the first candidate searching upward from rr_ptr, wrapping NUM_REQ-1 to 0.
REQ-014 SHALL update rr_ptr <= (granted index + 1) mod NUM_REQ on a grant; rr_ptr SHALL be unchanged when there is no grant.
REQ-015 SHALL register the granted tag and value into cdb_data with valid=1 at the clock edge, giving 1-cycle latency from an unbuffered fu_valid to cdb_data.valid.
REQ-016 SHALL drive cdb_data = {valid=0, rob_tag=0, value=0} for the following cycle when there is no grant.
REQ-017 Buffer update, bypass: !buf_valid[i] && fu_valid[i] && grant[i] -> no capture.
REQ-018 Buffer update, capture: !buf_valid[i] && fu_valid[i] && !grant[i] -> capture tag and value, buf_valid[i] <= 1.
REQ-019 Buffer update, drain: buf_valid[i] && grant[i] -> buf_valid[i] <= 0, so fu_ready[i] rises next cycle.
REQ-020 Buffer update, hold: buf_valid[i] && !grant[i] -> hold contents unchanged.
REQ-021 SHALL guarantee starvation freedom: a buffered entry is granted within NUM_REQ cycles.
REQ-022 SHALL never reorder results of the same requester.
REQ-023 SHALL keep a continuously granted requester streaming one result per cycle without buffering.
REQ-024 SHALL NOT inspect or arbitrate by rob_tag; duplicate tags pass through unchanged.

Reset
REQ-025 SHALL, on reset, clear all buf_valid to 0, set rr_ptr to 0 and set cdb_data to {0,0,0}.
REQ-026 SHALL make fu_ready all-ones in the cycle after reset.
REQ-027 SHALL silently discard buffered results when reset is asserted mid-operation, with no grant issued in the reset cycle.
REQ-028 SHALL give reset priority over every other update in the same cycle.

Configuration
REQ-029 SHALL support macro CDB_ARB_STATS_EN.
REQ-030 With CDB_ARB_STATS_EN defined, SHALL add output stall_count, NUM_REQ x 32.
REQ-031 With CDB_ARB_STATS_EN defined, stall_count[i] SHALL increment by 1 each cycle buf_valid[i] && !grant[i], saturate at all-ones, and reset to 0.
REQ-032 Without CDB_ARB_STATS_EN, the stall_count port and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-033 SHALL keep CDB_DATA (valid, rob_tag, value), `XLEN, `ROB_TAG_LEN and the new constant CDB_NUM_REQ in the shared sys_defs package.
REQ-034 SHALL place round-robin grant logic in a combinational sub-module rr_arbiter: inputs req and ptr, output one-hot grant.
REQ-035 SHALL keep buffers, rr_ptr and output register in cdb_arbiter.

Verification
REQ-036 Single request: fu_valid[2]=1, tag=3, value=0xDEAD at cycle 1 -> cdb_data={1,3,0xDEAD} at cycle 2; rr_ptr=3; fu_ready stays all-ones.
REQ-037 All-four simultaneous, rr_ptr=0: tags 0..3 presented once -> CDB emits tags 0,1,2,3 on consecutive cycles; fu_ready[1..3] low one cycle after capture, then rising in turn.
REQ-038 Wrap-around: rr_ptr=3, requests on FU3 and FU0 -> FU3 granted first, then FU0; rr_ptr ends at 1.
REQ-039 Streaming plus contention: FU0 valid every cycle, FU1 valid once -> FU1 granted within 2 cycles; FU0 order preserved; no lost or duplicated result.
REQ-040 Reset mid-operation: FU1 and FU3 buffered, reset asserted 1 cycle -> next cycle cdb_data.valid=0, fu_ready=4'b1111, and no stale result ever appears.
REQ-041 With CDB_ARB_STATS_EN: FU2 held 3 cycles behind others -> stall_count[2]=3.
